// File: rtl/serial_frame_rx.sv
// serial_frame_rx
// ---------------------------------------------------------------------------
// Bit-serial frame receiver, one bit per clock with no oversampling. It
// detects a start bit (0), shifts in DATA_BITS data bits LSB-first, optionally
// checks a parity bit, then checks STOP_BITS stop bits (1). A good frame loads
// data_out and pulses done for one cycle.
//
// Compile-time option:
//   SERIAL_FRAME_RX_PARITY_EN - builds the parity stage (PAR/PERR states,
//                               par_bad flag). When undefined, PARITY is
//                               ignored and parity_err is tied to 0.
//
// Parameters:
//   DATA_BITS  data bits per frame, 5..16
//   PARITY     0 = none, 1 = even, 2 = odd
//   STOP_BITS  1 or 2
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   in          serial line, idles high
//   data_out    last good word, bit 0 = first data bit received
//   done        1-cycle strobe, good frame completed
//   parity_err  1-cycle strobe, framing good but parity bad
//   frame_err   1-cycle strobe, a stop bit was sampled low
// ---------------------------------------------------------------------------
module serial_frame_rx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 done,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int               CNT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam bit PAR_ON  = (PARITY != 0);
  localparam bit PAR_ODD = (PARITY == 2);
`else
  // Without parity support the PARITY setting has no effect.
  localparam bit PAR_ON  = (PARITY != 0) && 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP,
    S_DONE,
    S_PERR,
    S_ERR
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;       // data bit index, then stop bit index
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 frame_err_q, frame_err_d;
  logic                 par_bad;

`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  assign par_bad = par_bad_q;
`else
  assign par_bad = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d signal gets a default before the case so no path leaves
    // one unassigned; that is what keeps this block from inferring latches.
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    frame_err_d = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    par_bad_d   = par_bad_q;
`endif

    case (state_q)
      // DONE and PERR act like IDLE: a low bit here is already the next
      // frame's start bit, which is what allows back-to-back frames.
      S_IDLE, S_DONE, S_PERR: begin
        if (!in) begin
          state_d = S_DATA;
          cnt_d   = '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_DATA: begin
        shift_d[cnt_q] = in;
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = PAR_ON ? S_PAR : S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef SERIAL_FRAME_RX_PARITY_EN
      S_PAR: begin
        // Even: XOR(data, parity) must be 0; odd: it must be 1.
        par_bad_d = (^shift_q) ^ in ^ PAR_ODD;
        cnt_d     = '0;
        state_d   = S_STOP;
      end
`endif

      S_STOP: begin
        if (!in) begin
          // Any low stop bit aborts at once, even the first of two.
          state_d     = S_ERR;
          frame_err_d = 1'b1;
          cnt_d       = '0;
        end else if (cnt_q == STOP_LAST) begin
          cnt_d = '0;
          if (par_bad) begin
            state_d = S_PERR;
          end else begin
            state_d = S_DONE;
            data_d  = shift_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Wait for the line to return high before looking for a start bit.
      S_ERR: begin
        if (in) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the shift and output registers are reset as well, because
      // data_out must read 0 immediately after any reset.
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef SERIAL_FRAME_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) par_bad_q <= 1'b0;
    else        par_bad_q <= par_bad_d;
  end
`endif

  // -------------------------------------------------------------------------
  // Outputs: registered decodes. frame_err is set only on the STOP->ERR
  // transition, so it covers the first ERR cycle and not the whole stay.
  // -------------------------------------------------------------------------
  assign data_out  = data_q;
  assign done      = (state_q == S_DONE);
  assign frame_err = frame_err_q;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  assign parity_err = (state_q == S_PERR);
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx
// Two receivers share clock and reset: dut_a is 8N1 with default parameters,
// dut_b is DATA_BITS=7, PARITY=1 (even), STOP_BITS=2. Each frame sent pushes
// the expected strobe kind, data_out value and strobe cycle into a per-DUT
// queue; a negedge monitor pops and compares whenever a strobe appears.
module tb_serial_frame_rx;

  localparam int A_BITS = 8;
  localparam int B_BITS = 7;
  localparam int A_STOP = 1;
  localparam int B_STOP = 2;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam bit B_PAR = 1'b1;
`else
  localparam bit B_PAR = 1'b0;
`endif

  typedef enum int {K_DONE, K_PERR, K_FERR} kind_e;
  typedef struct {
    kind_e       kind;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_a = 1'b1;
  logic       in_b = 1'b1;
  logic [7:0] data_a;
  logic       done_a, perr_a, ferr_a;
  logic [6:0] data_b;
  logic       done_b, perr_b, ferr_b;

  exp_t        q_a[$];
  exp_t        q_b[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [15:0] good_a = '0;
  logic [15:0] good_b = '0;

  serial_frame_rx u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .in        (in_a),
    .data_out  (data_a),
    .done      (done_a),
    .parity_err(perr_a),
    .frame_err (ferr_a)
  );

  serial_frame_rx #(
    .DATA_BITS(B_BITS),
    .PARITY   (1),
    .STOP_BITS(B_STOP)
  ) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .in        (in_b),
    .data_out  (data_b),
    .done      (done_b),
    .parity_err(perr_b),
    .frame_err (ferr_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------
  // Monitor: on every strobe, check exclusivity and compare with queue head.
  // ---------------------------------------------------------------------
  always @(negedge clk) begin : monitor
    logic        d, p, f;
    logic [15:0] dv;
    kind_e       k;
    exp_t        e;
    string       nm;
    for (int s = 0; s < 2; s++) begin
      d  = (s == 1) ? done_b : done_a;
      p  = (s == 1) ? perr_b : perr_a;
      f  = (s == 1) ? ferr_b : ferr_a;
      dv = (s == 1) ? {9'b0, data_b} : {8'b0, data_a};
      nm = (s == 1) ? "b" : "a";
      if (d || p || f) begin
        total++;
        if (!({d, p, f} inside {3'b100, 3'b010, 3'b001})) begin
          bad++;
          $display("FAIL %s_exclusive: done/parity_err/frame_err=%b%b%b, required one-hot", nm, d, p, f);
        end
        k = d ? K_DONE : (p ? K_PERR : K_FERR);
        total++;
        if ((s == 1 && q_b.size() == 0) || (s == 0 && q_a.size() == 0)) begin
          bad++;
          $display("FAIL %s_unexpected: got %s at cycle %0d data_out=%h, required no strobe", nm, k.name(), cyc, dv);
        end else begin
          e = (s == 1) ? q_b.pop_front() : q_a.pop_front();
          if (k !== e.kind || dv !== e.data || cyc !== e.cyc)
          begin
            bad++;
            $display("FAIL %s_strobe: got %s data_out=%h cycle=%0d, required %s data_out=%h cycle=%0d",
                     nm, k.name(), dv, cyc, e.kind.name(), e.data, e.cyc);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic drive_bit(input bit sel, input logic b);
    @(negedge clk);
    if (sel) in_b = b;
    else     in_a = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_a = 1'b1;
      in_b = 1'b1;
    end
  endtask

  // Sends one frame and pushes the expected outcome. The start bit is
  // sampled at edge start_edge; the frame's last bit at start_edge + L - 1,
  // and the strobe is visible right after that edge.
  task automatic send_frame(input bit sel, input logic [15:0] data, input bit use_par,
                            input logic par_bit, input logic [1:0] stops);
    int          nbits;
    int          nstop;
    int          start_edge;
    int          len;
    logic        x;
    logic [15:0] m;
    exp_t        e;
    nbits = sel ? B_BITS : A_BITS;
    nstop = sel ? B_STOP : A_STOP;
    drive_bit(sel, 1'b0);
    start_edge = cyc + 1;
    x = 1'b0;
    m = '0;
    for (int i = 0; i < nbits; i++) begin
      drive_bit(sel, data[i]);
      x    = x ^ data[i];
      m[i] = data[i];
    end
    if (use_par) drive_bit(sel, par_bit);
    for (int i = 0; i < nstop; i++) begin
      drive_bit(sel, stops[i]);
      if (!stops[i]) begin
        e.kind = K_FERR;
        e.data = sel ? good_b : good_a;
        e.cyc  = start_edge + 1 + nbits + int'(use_par) + i;
        if (sel) q_b.push_back(e);
        else     q_a.push_back(e);
        return;
      end
    end
    len   = 1 + nbits + int'(use_par) + nstop;
    e.cyc = start_edge + len - 1;
    if (use_par && (x ^ par_bit)) begin
      e.kind = K_PERR;
      e.data = sel ? good_b : good_a;
    end else begin
      e.kind = K_DONE;
      e.data = m;
      if (sel) good_b = m;
      else     good_a = m;
    end
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
    total++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: pending strobes a=%0d b=%0d, required 0", name, q_a.size(), q_b.size());
      q_a.delete();
      q_b.delete();
    end
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    #12;
    total++;
    if ({data_a, done_a, perr_a, ferr_a} !== 11'b0) begin
      bad++;
      $display("FAIL reset_a: data_out=%h done=%b parity_err=%b frame_err=%b, required all 0",
               data_a, done_a, perr_a, ferr_a);
    end
    total++;
    if ({data_b, done_b, perr_b, ferr_b} !== 10'b0) begin
      bad++;
      $display("FAIL reset_b: data_out=%h done=%b parity_err=%b frame_err=%b, required all 0",
               data_b, done_b, perr_b, ferr_b);
    end
    @(negedge clk);
    reset = 1'b1;
    idle(3);
  endtask

  task automatic test_basic();
    send_frame(1'b0, 16'h00A5, 1'b0, 1'b0, 2'b11);
    idle(3);
    wait_drain("basic");
  endtask

  task automatic test_frame_err();
    send_frame(1'b0, 16'h005A, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    idle(2);
    send_frame(1'b0, 16'h0012, 1'b0, 1'b0, 2'b11);
    idle(3);
    wait_drain("frame_err");
  endtask

  task automatic test_back_to_back();
    send_frame(1'b0, 16'h003C, 1'b0, 1'b0, 2'b11);
    send_frame(1'b0, 16'h00C3, 1'b0, 1'b0, 2'b11);
    idle(3);
    wait_drain("back_to_back");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      send_frame(1'b0, 16'($urandom_range(0, 255)), 1'b0, 1'b0, 2'b11);
      idle(int'($urandom_range(0, 3)));
    end
    send_frame(1'b0, 16'h007E, 1'b0, 1'b0, 2'b11);
    idle(3);
    wait_drain("random");
  endtask

  task automatic test_parity();
    // 0x2A has three ones: even parity bit 1 is good. 0x55 has four ones.
    send_frame(1'b1, 16'h002A, B_PAR, 1'b1, 2'b11);
    send_frame(1'b1, 16'h0055, B_PAR, 1'b1, 2'b11);
    idle(2);
    send_frame(1'b1, 16'h0055, B_PAR, 1'b0, 2'b11);
    idle(3);
    wait_drain("parity");
  endtask

  task automatic test_two_stop();
    send_frame(1'b1, 16'h0033, B_PAR, 1'b0, 2'b01);
    idle(2);
    send_frame(1'b1, 16'h0014, B_PAR, 1'b0, 2'b11);
    idle(3);
    wait_drain("two_stop");
  endtask

  task automatic test_reset_mid();
    total++;
    if ({8'b0, data_a} !== good_a) begin
      bad++;
      $display("FAIL pre_reset_data: data_out=%h, required %h", data_a, good_a);
    end
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({data_a, done_a, perr_a, ferr_a} !== 11'b0 || data_b !== 7'b0) begin
      bad++;
      $display("FAIL reset_mid: data_out_a=%h done=%b parity_err=%b frame_err=%b data_out_b=%h, required all 0",
               data_a, done_a, perr_a, ferr_a, data_b);
    end
    good_a = '0;
    good_b = '0;
    in_a   = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    send_frame(1'b0, 16'h0081, 1'b0, 1'b0, 2'b11);
    idle(3);
    wait_drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame_err();
    test_back_to_back();
    test_random();
`ifdef SERIAL_FRAME_RX_PARITY_EN
    test_parity();
`endif
    test_two_stop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
